// File: rtl/emif_dout_arbiter.sv
// rtl/emif_dout_arbiter.sv - round-robin arbiter driving a shared registered EMIF output data bus
//
// Two requesters compete for one output bus. The winner streams len beats,
// each held for HOLD_CYCLES clocks. A turnaround gap of TURN_CYCLES idle
// clocks with the bus disabled follows before the next owner is chosen.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req0/1, len0/1        level request and beat count (len latched at grant)
//   dat0/1                current beat data of each requester
//   gnt0/1                bus owned by requester 0/1
//   rdy0/1                one-clock pulse: current beat consumed, present next
//   bus_data              registered data feeding the output buffers
//   bus_oe, bus_strb      bus driven / last clock of a beat
//   busy                  arbiter not idle

module emif_dout_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [7:0]            len0,
    input  logic [DATA_WIDTH-1:0] dat0,
    output logic                  gnt0,
    output logic                  rdy0,
    input  logic                  req1,
    input  logic [7:0]            len1,
    input  logic [DATA_WIDTH-1:0] dat1,
    output logic                  gnt1,
    output logic                  rdy1,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_oe,
    output logic                  bus_strb,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        TURN
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] TURN_LAST = 3'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t                state, state_n;
    logic                  owner, owner_n;     // requester owning the current burst
    logic                  last, last_n;       // requester granted most recently
    logic [3:0]            hold_cnt, hold_n;   // clocks already spent in the current beat
    logic [7:0]            beat_cnt, beat_n;   // beats remaining, including the current one
    logic [2:0]            turn_cnt, turn_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;

    logic elig0, elig1, pick1, beat_end;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last;
        hold_n   = hold_cnt;
        beat_n   = beat_cnt;
        turn_n   = turn_cnt;
        data_n   = data_q;

        elig0    = req0 && (len0 != 8'd0);
        elig1    = req1 && (len1 != 8'd0);
        // Requester 1 wins when alone, or when both ask and 0 was served last.
        pick1    = elig1 && (!elig0 || (last == 1'b0));
        beat_end = (state == XFER) && (hold_cnt == HOLD_LAST);

        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_n = XFER;
                    owner_n = pick1;
                    last_n  = pick1;
                    beat_n  = pick1 ? len1 : len0;
                    hold_n  = 4'd0;
                    data_n  = pick1 ? dat1 : dat0;
                end
            end
            XFER: begin
                if (beat_end) begin
                    hold_n = 4'd0;
                    if (beat_cnt == 8'd1) begin
                        turn_n = 3'd0;
                        if (TURN_CYCLES == 0) begin
                            state_n = IDLE;
                        end else begin
                            state_n = TURN;
                        end
                    end else begin
                        // Next beat loads back-to-back; requester updated dat during rdy.
                        beat_n = beat_cnt - 8'd1;
                        data_n = owner ? dat1 : dat0;
                    end
                end else begin
                    hold_n = hold_cnt + 4'd1;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_n = IDLE;
                end else begin
                    turn_n = turn_cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;   // makes requester 0 the first winner
            hold_cnt <= 4'd0;
            beat_cnt <= 8'd0;
            turn_cnt <= 3'd0;
            data_q   <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            beat_cnt <= beat_n;
            turn_cnt <= turn_n;
            data_q   <= data_n;
        end
    end

    assign gnt0     = (state == XFER) && !owner;
    assign gnt1     = (state == XFER) && owner;
    assign rdy0     = beat_end && !owner;
    assign rdy1     = beat_end && owner;
    assign bus_oe   = (state == XFER);
    assign bus_strb = beat_end;
    assign busy     = (state != IDLE);
    assign bus_data = data_q;

endmodule

// File: tb/tb_emif_dout_arbiter.sv
// tb/tb_emif_dout_arbiter.sv - self-checking bench for emif_dout_arbiter

module tb_emif_dout_arbiter;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req  [2][2];
    logic [7:0]    len  [2][2];
    logic [DW-1:0] dat  [2][2];
    logic          gnt  [2][2];
    logic          rdy  [2][2];
    logic [DW-1:0] bdata[2];
    logic          oe   [2];
    logic          strb [2];
    logic          busy [2];

    emif_dout_arbiter #(.DATA_WIDTH(DW), .HOLD_CYCLES(2), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req[0][0]), .len0(len[0][0]), .dat0(dat[0][0]), .gnt0(gnt[0][0]), .rdy0(rdy[0][0]),
        .req1(req[0][1]), .len1(len[0][1]), .dat1(dat[0][1]), .gnt1(gnt[0][1]), .rdy1(rdy[0][1]),
        .bus_data(bdata[0]), .bus_oe(oe[0]), .bus_strb(strb[0]), .busy(busy[0])
    );

    emif_dout_arbiter #(.DATA_WIDTH(DW), .HOLD_CYCLES(1), .TURN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req[1][0]), .len0(len[1][0]), .dat0(dat[1][0]), .gnt0(gnt[1][0]), .rdy0(rdy[1][0]),
        .req1(req[1][1]), .len1(len[1][1]), .dat1(dat[1][1]), .gnt1(gnt[1][1]), .rdy1(rdy[1][1]),
        .bus_data(bdata[1]), .bus_oe(oe[1]), .bus_strb(strb[1]), .busy(busy[1])
    );

    // Reference model: owner (-1 = nobody), beats left, clocks spent in beat (1..H),
    // remaining turnaround clocks, last winner, and the data word on the bus.
    int          m_owner[2];
    int          m_left [2];
    int          m_hold [2];
    int          m_cool [2];
    int          m_last [2];
    logic [DW-1:0] m_data[2];

    int checks   = 0;
    int failures = 0;

    function automatic int hold_of(input int c);
        return (c == 0) ? 2 : 1;
    endfunction

    function automatic int turn_of(input int c);
        return (c == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, c, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            int  w;
            bit  e0, e1;
            if (rst) begin
                m_owner[c] = -1;
                m_cool[c]  = 0;
                m_last[c]  = 1;
                m_data[c]  = '0;
            end else if (m_owner[c] >= 0) begin
                if (m_hold[c] == hold_of(c)) begin
                    if (m_left[c] == 1) begin
                        m_owner[c] = -1;
                        m_cool[c]  = turn_of(c);
                    end else begin
                        m_left[c]--;
                        m_hold[c] = 1;
                        m_data[c] = dat[c][m_owner[c]];
                    end
                end else begin
                    m_hold[c]++;
                end
            end else if (m_cool[c] > 0) begin
                m_cool[c]--;
            end else begin
                e0 = req[c][0] && (len[c][0] != 0);
                e1 = req[c][1] && (len[c][1] != 0);
                if (e0 && e1)  w = (m_last[c] == 0) ? 1 : 0;
                else if (e0)   w = 0;
                else if (e1)   w = 1;
                else           w = -1;
                if (w >= 0) begin
                    m_owner[c] = w;
                    m_last[c]  = w;
                    m_left[c]  = int'(len[c][w]);
                    m_hold[c]  = 1;
                    m_data[c]  = dat[c][w];
                end
            end
        end
    endtask

    task automatic compare();
        for (int c = 0; c < 2; c++) begin
            bit beat_last;
            beat_last = (m_owner[c] >= 0) && (m_hold[c] == hold_of(c));
            check("gnt0", c, gnt[c][0], m_owner[c] == 0);
            check("gnt1", c, gnt[c][1], m_owner[c] == 1);
            check("rdy0", c, rdy[c][0], beat_last && m_owner[c] == 0);
            check("rdy1", c, rdy[c][1], beat_last && m_owner[c] == 1);
            check("bus_oe", c, oe[c], m_owner[c] >= 0);
            check("bus_strb", c, strb[c], beat_last);
            check("busy", c, busy[c], (m_owner[c] >= 0) || (m_cool[c] > 0));
            check("bus_data", c, bdata[c], m_data[c]);
            check("oe_is_gnt_or", c, oe[c], gnt[c][0] | gnt[c][1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 2; k++) begin
                req[c][k] = 1'b0;
                len[c][k] = 8'd0;
                dat[c][k] = '0;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] seq[3];
        int di, g0, g1, idle, nrdy, first_rdy, last_rdy;
        bit prev_oe, found;
        int order[$];

        for (int c = 0; c < 2; c++) begin
            m_owner[c] = -1; m_left[c] = 0; m_hold[c] = 0;
            m_cool[c] = 0; m_last[c] = 1; m_data[c] = '0;
        end
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        check("reset_busy", 0, busy[0], 1'b0);
        check("reset_data", 0, bdata[0], 16'h0000);
        rst = 1'b0;
        tick();

        // Single burst of three beats, data advanced on each rdy0.
        seq[0] = 16'h00A1; seq[1] = 16'h00B2; seq[2] = 16'h00C3;
        di = 0;
        req[0][0] = 1'b1; len[0][0] = 8'd3; dat[0][0] = seq[0];
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) begin
                req[0][0] = 1'b0;
                len[0][0] = 8'd1;
            end
            check("t1_gnt0", 0, gnt[0][0], (i >= 1 && i <= 6));
            check("t1_rdy0", 0, rdy[0][0], (i == 2 || i == 4 || i == 6));
            if (i <= 6) check("t1_data", 0, bdata[0], seq[(i - 1) / 2]);
            if (i == 8) check("t1_busy_low", 0, busy[0], 1'b0);
            if (rdy[0][0] && di < 2) begin
                di++;
                dat[0][0] = seq[di];
            end
        end

        // Zero-length request must never be granted.
        clear_inputs();
        req[0][0] = 1'b1; len[0][0] = 8'd2;
        req[0][1] = 1'b1; len[0][1] = 8'd0;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 30; i++) begin
            dat[0][0] = DW'($urandom); dat[0][1] = DW'($urandom);
            tick();
            g0 += int'(gnt[0][0]);
            g1 += int'(gnt[0][1]);
        end
        check("t2_gnt1_cycles", 0, g1, 0);
        check("t2_gnt0_seen", 0, g0 > 0, 1'b1);

        // Contention after reset: alternating grants with TURN+1 idle clocks.
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req[0][0] = 1'b1; len[0][0] = 8'd1;
        req[0][1] = 1'b1; len[0][1] = 8'd1;
        idle = 0; prev_oe = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (oe[0] && !prev_oe) begin
                if (order.size() > 0 && order.size() < 4) check("t3_gap", 0, idle, 2);
                order.push_back(gnt[0][1] ? 1 : 0);
                idle = 0;
            end
            if (!oe[0]) idle++;
            prev_oe = oe[0];
        end
        check("t3_grant_count", 0, order.size() >= 4, 1'b1);
        if (order.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", 0, order[i], i % 2);
        end

        // 255-beat burst on the HOLD=1/TURN=0 instance, then fastest regrant.
        clear_inputs();
        req[1][0] = 1'b1; len[1][0] = 8'd255;
        nrdy = 0; first_rdy = -1; last_rdy = -1;
        for (int i = 1; i <= 258; i++) begin
            tick();
            if (i == 1) begin
                req[1][0] = 1'b0; len[1][0] = 8'd0;
            end
            if (i <= 256 && rdy[1][0]) begin
                nrdy++;
                if (first_rdy < 0) first_rdy = i;
                last_rdy = i;
                if (nrdy == 255) begin
                    req[1][0] = 1'b1; len[1][0] = 8'd1;
                end
            end
            if (i == 256) check("t4_idle_clock", 1, gnt[1][0], 1'b0);
            if (i == 257) begin
                check("t4_regrant", 1, gnt[1][0], 1'b1);
                req[1][0] = 1'b0; len[1][0] = 8'd0;
            end
            dat[1][0] = DW'($urandom);
        end
        check("t4_rdy_count", 1, nrdy, 255);
        check("t4_first_rdy", 1, first_rdy, 1);
        check("t4_last_rdy", 1, last_rdy, 255);

        // Reset in the second beat of a 4-beat burst from requester 1.
        clear_inputs();
        req[0][1] = 1'b1; len[0][1] = 8'd4; dat[0][1] = 16'h5A5A;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (rdy[0][1]) found = 1'b1;
        end
        check("t5_first_beat", 0, found, 1'b1);
        dat[0][1] = 16'h3C3C;
        tick();
        check("t5_in_beat2", 0, gnt[0][1], 1'b1);
        rst = 1'b1;
        req[0][0] = 1'b1; len[0][0] = 8'd1; len[0][1] = 8'd1;
        tick();
        rst = 1'b0;
        check("t5_rst_gnt0", 0, gnt[0][0], 1'b0);
        check("t5_rst_gnt1", 0, gnt[0][1], 1'b0);
        check("t5_rst_rdy1", 0, rdy[0][1], 1'b0);
        check("t5_rst_oe", 0, oe[0], 1'b0);
        check("t5_rst_strb", 0, strb[0], 1'b0);
        check("t5_rst_busy", 0, busy[0], 1'b0);
        check("t5_rst_data", 0, bdata[0], 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (oe[0]) begin
                found = 1'b1;
                check("t5_first_after_rst", 0, gnt[0][0], 1'b1);
            end
        end
        check("t5_grant_seen", 0, found, 1'b1);

        // Randomized traffic on both instances, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 2; k++) begin
                    int r;
                    if ($urandom_range(0, 7) == 0) req[c][k] = ~req[c][k];
                    if ($urandom_range(0, 7) == 0) begin
                        r = $urandom_range(0, 9);
                        if (r <= 2)      len[c][k] = 8'd0;
                        else if (r <= 8) len[c][k] = 8'($urandom_range(1, 4));
                        else             len[c][k] = 8'($urandom_range(5, 40));
                    end
                    dat[c][k] = DW'($urandom);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emif_dout_arbiter.md
EMIF_DOUT_ARBITER -- requirements
Module: emif_dout_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the shared output bus and each requester data port.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: clocks each beat stays on the bus; legal range 1..15.
REQ-003 SHALL have parameter TURN_CYCLES, default 1: idle clocks with bus_oe low between owners; legal range 0..7.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports in order: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have, for each requester k in {0,1}: reqk input 1, transfer request (level); lenk input 8, beat count, sampled at grant; datk input DATA_WIDTH, current beat data; gntk output 1, bus owned by k; rdyk output 1, one-clock pulse when the current beat of k is consumed.
REQ-006 SHALL have bus_data output DATA_WIDTH, the registered data feeding the output buffer bank.
REQ-007 SHALL have bus_oe output 1, high while a beat is driven.
REQ-008 SHALL have bus_strb output 1, high during the last clock of each beat.
REQ-009 SHALL have busy output 1, high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, XFER and TURN.
REQ-011 In IDLE, a requester SHALL be eligible only when reqk=1 and lenk!=0; requests with len=0 SHALL be ignored and SHALL never receive a grant.
REQ-012 Arbitration SHALL be round-robin: with both requesters eligible, the one not granted most recently wins; after reset, requester 0 has priority.
REQ-013 If the winner is decided in IDLE at cycle N, then at cycle N+1 gntk SHALL be 1, bus_oe 1, bus_data equal to datk sampled at N, and state XFER.
REQ-014 lenk SHALL be latched at cycle N; later changes to lenk, or deassertion of reqk, SHALL NOT shorten or abort the burst.
REQ-015 Each beat SHALL occupy exactly HOLD_CYCLES clocks with bus_data stable; bus_strb and rdyk SHALL be 1 only in the last clock of the beat.
REQ-016 On the clock after rdyk, bus_data SHALL load the next beat from datk with no gap; the requester SHALL present the next beat in the rdyk cycle.
REQ-017 After the last beat, gntk and bus_oe SHALL fall on the next clock; state SHALL be TURN for TURN_CYCLES clocks and then IDLE; if TURN_CYCLES=0, the state SHALL go directly to IDLE.
REQ-018 The beat counter SHALL be 8 bits and the hold counter 4 bits, with no wrap-around; len=255 SHALL yield exactly 255 beats.
REQ-019 At most one gntk SHALL be high at any time; bus_oe SHALL equal gnt0|gnt1.
REQ-020 bus_data SHALL keep its last value when bus_oe=0; no arbitration decision SHALL be made in TURN.
REQ-021 Minimum idle between the end of one burst and the next grant SHALL be TURN_CYCLES+1 clocks.

Reset
REQ-022 While rst=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 on the next edge: gnt0, gnt1, rdy0, rdy1, bus_oe, bus_strb, busy and bus_data.
REQ-023 Reset asserted during a burst SHALL abort it immediately with no further rdyk pulses, and the round-robin pointer SHALL return to requester 0.

Verification
REQ-024 Single burst with HOLD_CYCLES=2, TURN_CYCLES=1, req0 and len0=3 at cycle 0, dat0 advancing on rdy0 (A,B,C) -> gnt0 high during cycles 1-6, bus_data A/A/B/B/C/C, rdy0 and bus_strb at cycles 2, 4 and 6, busy low at cycle 8.
REQ-025 Contention with req0 and req1 both held, len=1 each -> grant order 0,1,0,1 with TURN_CYCLES+1 idle clocks between grants and never both gnt high.
REQ-026 req1 with len1=0 alongside req0 with len0=2 -> only gnt0 is ever asserted; req1 is never granted.
REQ-027 HOLD_CYCLES=1, TURN_CYCLES=0, len0=255 -> 255 consecutive rdy0 pulses, then a new grant possible 1 clock after the last beat.
REQ-028 rst asserted in the 2nd beat of a 4-beat burst of requester 1 -> all outputs 0 on the next edge; after release with both requesting, requester 0 is granted first.
